mac_operand_sequencer: RTL and testbench

- Initiator-side driver for the MAC go/done operand protocol.
- Holds a small buffer of (a,b) operand pairs loaded by a host. On start, it presents each pair to the MAC, pulses go, and waits for done.
- After the last pair it captures the 12-bit accumulated result and reports it to the host.
- Sits between the host/memory side and the MAC top; it is the producer of a/b/go and the consumer of out/done.

---
 rtl/mac_operand_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// Initiator for the MAC go/done protocol: replays buffered (a,b) pairs and captures the final sum.
// Optional MAC_SEQ_CHECK_EN adds a shadow accumulator and a chk_fail output.
module mac_operand_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DW      = 4,
    parameter int OW      = 12,
    parameter int TIMEOUT = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk_out,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_a,
    input  logic [DW-1:0] wr_b,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic          mac_go,
    input  logic          mac_done,
    input  logic [OW-1:0] mac_out,
    output logic [OW-1:0] result,
    output logic          res_valid,
    output logic          err,
`ifdef MAC_SEQ_CHECK_EN
    output logic          chk_fail,
`endif
    output logic [2:0]    dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // Handshake: mac_go is a one-cycle issue pulse with mac_a/mac_b stable from that cycle
    // until the pair completes; mac_done is a one-cycle completion pulse, mac_out valid with it.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_ERR
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] buf_a [DEPTH];
    logic [DW-1:0] buf_b [DEPTH];
    logic [AW:0]   len_q;
    logic [AW-1:0] idx;
    logic [CW-1:0] wait_cnt;
    logic          start_ok;
    logic          last_pair;
    logic          timeout_hit;

    assign start_ok    = start && (len != '0) && (len <= (AW+1)'(DEPTH));
    assign last_pair   = ({1'b0, idx} == (len_q - (AW+1)'(1)));
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
    assign dbg_state   = state;

    // Buffer is never reset; slots are undefined until written.
    always_ff @(posedge clk_out) begin
        if (wr_en) begin
            buf_a[wr_addr] <= wr_a;
            buf_b[wr_addr] <= wr_b;
        end
    end

    always_ff @(posedge clk_out) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        mac_go    = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE:    if (start_ok) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_ISSUE;
            S_ISSUE: begin
                mac_go    = 1'b1;
                state_nxt = S_WAIT;
            end
            // Completion has priority over a timeout landing on the same cycle.
            S_WAIT: begin
                if (mac_done)         state_nxt = last_pair ? S_CAPTURE : S_LOAD;
                else if (timeout_hit) state_nxt = S_ERR;
            end
            S_CAPTURE: begin
                res_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            len_q    <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        len_q <= len;
                        idx   <= '0;
                        err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    mac_a <= buf_a[idx];
                    mac_b <= buf_b[idx];
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (mac_done) begin
                        if (last_pair) result <= mac_out;
                        else           idx    <= idx + AW'(1);
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MAC_SEQ_CHECK_EN
    logic [OW-1:0]   shadow_acc;
    logic [2*DW-1:0] pair_prod;

    assign pair_prod = buf_a[idx] * buf_b[idx];

    // Shadow sum is compared against the MAC's final value on the edge that loads result,
    // so chk_fail becomes visible together with res_valid.
    always_ff @(posedge clk_out) begin
        if (!rst) begin
            shadow_acc <= '0;
            chk_fail   <= 1'b0;
        end else if (state == S_IDLE && start_ok) begin
            shadow_acc <= '0;
            chk_fail   <= 1'b0;
        end else if (state == S_ISSUE) begin
            shadow_acc <= shadow_acc + OW'(pair_prod);
        end else if (state == S_WAIT && mac_done && last_pair) begin
            if (shadow_acc != mac_out) chk_fail <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: a latency-programmable MAC model, a negedge monitor and
// directed/randomized sequences checked against sums and timings computed from the buffer contents.
module tb_mac_operand_sequencer;

  localparam int DEPTH = 8;
  localparam int DW = 4;
  localparam int OW = 12;
  localparam int TIMEOUT = 64;
  localparam int AW = 3;

  logic clk_out = 1'b0;
  logic rst;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_a;
  logic [DW-1:0] wr_b;
  logic start;
  logic [AW:0] len;
  logic busy;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic mac_go;
  logic mac_done = 1'b0;
  logic [OW-1:0] mac_out = '0;
  logic [OW-1:0] result;
  logic res_valid;
  logic err;
  logic [2:0] dbg_state;
`ifdef MAC_SEQ_CHECK_EN
  logic chk_fail;
`endif

  mac_operand_sequencer #(.DEPTH(DEPTH), .DW(DW), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
    .clk_out(clk_out), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .start(start), .len(len), .busy(busy), .mac_a(mac_a), .mac_b(mac_b), .mac_go(mac_go),
    .mac_done(mac_done), .mac_out(mac_out), .result(result), .res_valid(res_valid), .err(err),
`ifdef MAC_SEQ_CHECK_EN
    .chk_fail(chk_fail),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_out = ~clk_out;

  int cyc = 0;
  always @(posedge clk_out) cyc++;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- MAC model ----------------
  // done arrives mac_lat cycles after the go cycle; out is the running sum of a*b (+ bias).
  int mac_lat = 3;
  bit mac_never = 1'b0;
  int mac_bias = 0;
  int mac_cd = 0;
  int mac_acc = 0;
  int mac_tmp;

  always @(negedge clk_out) begin
    mac_done = 1'b0;
    if (busy !== 1'b1) mac_acc = 0;
    if (mac_cd > 0) begin
      mac_cd--;
      if (mac_cd == 0 && !mac_never) begin
        mac_tmp = mac_acc + mac_bias;
        mac_done = 1'b1;
        mac_out = mac_tmp[OW-1:0];
      end
    end
    if (mac_go === 1'b1) begin
      mac_acc += int'(mac_a) * int'(mac_b);
      mac_cd = mac_lat;
    end
  end

  // ---------------- monitor ----------------
  int go_cnt = 0;
  int rv_cnt = 0;
  int rv_cycle = 0;
  logic [OW-1:0] rv_result;
  logic rv_chk = 1'b0;
  logic [2*DW-1:0] obs_ab[256];

  always @(negedge clk_out) begin
    if (mac_go === 1'b1) begin
      obs_ab[go_cnt % 256] = {mac_a, mac_b};
      go_cnt++;
    end
    if (res_valid === 1'b1) begin
      rv_cnt++;
      rv_result = result;
      rv_cycle = cyc;
`ifdef MAC_SEQ_CHECK_EN
      rv_chk = chk_fail;
`endif
    end
  end

  // ---------------- reference buffer / scoreboard ----------------
  logic [DW-1:0] ref_a[DEPTH];
  logic [DW-1:0] ref_b[DEPTH];
  logic [2*DW-1:0] exp_q[$];
  int st_cyc, go0, rv0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_out);
    #1;
  endtask

  task automatic write_slot(input int addr, input int a, input int b);
    wr_en = 1'b1;
    wr_addr = AW'(addr);
    wr_a = DW'(a);
    wr_b = DW'(b);
    ref_a[addr] = DW'(a);
    ref_b[addr] = DW'(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    go0 = go_cnt;
    rv0 = rv_cnt;
    start = 1'b1;
    len = (AW+1)'(n);
    st_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_seq(input string tag, input int n, input int lat, input int bias);
    int sum;
    int k;
    logic [OW-1:0] exp_res;
    logic [2*DW-1:0] e;
    sum = bias;
    for (int i = 0; i < n; i++) begin
      sum += int'(ref_a[i]) * int'(ref_b[i]);
      exp_q.push_back({ref_a[i], ref_b[i]});
    end
    exp_res = sum[OW-1:0];
    k = 0;
    while (rv_cnt == rv0 && k < 3000) begin
      tick();
      k++;
    end
    check({tag, " res_valid count"}, rv_cnt - rv0, 1);
    check({tag, " result"}, rv_result, exp_res);
    check({tag, " start-to-res_valid cycles"}, rv_cycle - st_cyc, n * (2 + lat) + 1);
    check({tag, " go pulses"}, go_cnt - go0, n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check({tag, " pair a/b"}, obs_ab[(go0 + i) % 256], e);
    end
    check({tag, " err"}, err, 0);
    tick();
    check({tag, " busy after res_valid"}, busy, 0);
    check({tag, " result holds"}, result, exp_res);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, lat, st;
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_a = '0;
    wr_b = '0;
    start = 1'b0;
    len = '0;
    repeat (3) tick();
    check("reset outputs", {busy, mac_go, res_valid, err, mac_a, mac_b, result}, 0);
    check("reset state idle", dbg_state, 0);
    rst = 1'b1;
    tick();

    // Basic three-pair run: 12 + 10 + 7 = 29
    write_slot(0, 3, 4);
    write_slot(1, 2, 5);
    write_slot(2, 1, 7);
    mac_lat = 3;
    pulse_start(3);
    check("basic busy after start", busy, 1);
    finish_seq("basic", 3, 3, 0);

    // Full buffer of 15*15: 8 * 225 = 1800
    for (int i = 0; i < DEPTH; i++) write_slot(i, 15, 15);
    mac_lat = $urandom_range(1, 4);
    pulse_start(8);
    finish_seq("full", 8, mac_lat, 0);

    // Timeout: MAC never answers
    mac_never = 1'b1;
    pulse_start(2);
    st = st_cyc;
    while (cyc < st + 66) tick();
    check("timeout err before limit", err, 0);
    check("timeout busy in wait", busy, 1);
    tick();
    check("timeout err set", err, 1);
    check("timeout busy in err", busy, 1);
    check("timeout no go in err", mac_go, 0);
    tick();
    check("timeout back to idle", busy, 0);
    check("timeout err sticky", err, 1);
    check("timeout go pulses", go_cnt - go0, 1);
    check("timeout no res_valid", rv_cnt - rv0, 0);
    mac_never = 1'b0;
    mac_lat = 2;
    pulse_start(1);
    check("err cleared by start", err, 0);
    finish_seq("after timeout", 1, 2, 0);

    // Start while busy and invalid lengths in idle are ignored
    mac_lat = 3;
    pulse_start(2);
    repeat (3) tick();
    start = 1'b1;
    len = 4'd1;
    tick();
    start = 1'b0;
    finish_seq("start while busy", 2, 3, 0);
    go0 = go_cnt;
    start = 1'b1;
    len = 4'd0;
    tick();
    len = 4'd9;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("bad len stays idle", busy, 0);
    check("bad len no go", go_cnt - go0, 0);

    // Reset during WAIT of pair 1
    mac_lat = 4;
    pulse_start(3);
    st = st_cyc;
    while (cyc < st + 10) tick();
    check("pre-reset in flight", busy, 1);
    rst = 1'b0;
    tick();
    check("mid reset outputs", {busy, mac_go, res_valid, err, mac_a, mac_b, result}, 0);
    rst = 1'b1;
    repeat (6) tick();
    check("late done ignored busy", busy, 0);
    check("late done no res_valid", rv_cnt - rv0, 0);
    check("reset go pulses", go_cnt - go0, 2);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) write_slot(i, $urandom_range(0, 15), $urandom_range(0, 15));
      n = $urandom_range(1, DEPTH);
      lat = $urandom_range(1, 6);
      mac_lat = lat;
      pulse_start(n);
      finish_seq("random", n, lat, 0);
    end

`ifdef MAC_SEQ_CHECK_EN
    write_slot(0, 3, 4);
    write_slot(1, 2, 5);
    write_slot(2, 1, 7);
    mac_lat = 3;
    mac_bias = -1;
    pulse_start(3);
    finish_seq("chk bad mac", 3, 3, -1);
    check("chk_fail with res_valid", rv_chk, 1);
    mac_bias = 0;
    pulse_start(3);
    check("chk_fail cleared on start", chk_fail, 0);
    finish_seq("chk good mac", 3, 3, 0);
    check("chk_fail clean run", rv_chk, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
